imem_port_arbiter: RTL and testbench

- Shares the single-port, word-addressed instruction memory between two requesters: the core fetch unit (read) and the program loader (write).
- Provides valid/ready request handshakes, a 1-cycle registered fetch response, starvation protection for fetch, and a program-lock mode that fences fetch out while the loader rewrites the image.
- Sits between the fetch stage / loader and the instruction memory array.

---
 rtl/imem_pkg.sv | 36 +++
 rtl/imem_addr_decode.sv | 30 +++
 rtl/imem_port_arbiter.sv | 166 ++++++++++++++++
 tb/tb_imem_port_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// ==== imem_pkg : shared types, constants and address decode for the imem port arbiter (rev 1.0) ====
`default_nettype none

package imem_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0033;

    // Decode is done at a fixed wide width so one function serves any ADDR_W up to this.
    localparam int DEC_AW = 128;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        LOCKED = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [31:0] index;
        logic        oob;
        logic        misaligned;
    } addr_dec_t;

    function automatic addr_dec_t decode_addr(input logic [DEC_AW-1:0] addr,
                                              input int unsigned       depth);
        addr_dec_t         d;
        logic [DEC_AW-1:0] limit;
        limit        = DEC_AW'(depth) << 2;
        d.index      = 32'((addr >> 2) & DEC_AW'(depth - 1));
        d.oob        = (addr >= limit);
        d.misaligned = (addr[1:0] != 2'b00);
        return d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/imem_addr_decode.sv
// ==== imem_addr_decode : byte address -> word index / out-of-bounds / misaligned flags (rev 1.0) ====
`default_nettype none

module imem_addr_decode
    import imem_pkg::*;
#(
    parameter  int ADDR_W = 64,
    parameter  int DEPTH  = 1024,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic [IDX_W-1:0]  index_o,
    output logic              oob_o,
    output logic              misaligned_o
);

    logic [DEC_AW-1:0] w_addr_ext;
    addr_dec_t         w_dec;
    logic              w_unused_idx_hi;

    assign w_addr_ext      = DEC_AW'(addr_i);
    assign w_dec           = decode_addr(w_addr_ext, DEPTH);
    assign index_o         = w_dec.index[IDX_W-1:0];
    assign oob_o           = w_dec.oob;
    assign misaligned_o    = w_dec.misaligned;
    assign w_unused_idx_hi = ^w_dec.index[31:IDX_W];

endmodule

`default_nettype wire

// File: rtl/imem_port_arbiter.sv
// ==== imem_port_arbiter : fetch/loader arbitration for a single-port instruction memory (rev 1.0) ====
`default_nettype none

module imem_port_arbiter
    import imem_pkg::*;
#(
    parameter  int          ADDR_W    = 64,
    parameter  int          DEPTH     = 1024,
    parameter  logic [31:0] NOP_INSTR = imem_pkg::NOP_INSTR,
    parameter  int          MAX_STALL = 4,
    localparam int          IDX_W     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_valid_i,
    output logic              fetch_ready_o,
    input  logic [ADDR_W-1:0] fetch_addr_i,
    output logic              fetch_rsp_valid_o,
    output logic [31:0]       fetch_rsp_instr_o,
    output logic              fetch_rsp_err_o,
    input  logic              load_valid_i,
    output logic              load_ready_o,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic [31:0]       load_data_i,
    output logic              load_err_o,
    input  logic              prog_lock_i,
    output logic              lock_active_o,
    output logic              load_done_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [IDX_W-1:0]  mem_index_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i
);

    localparam int               CNT_W     = $clog2(MAX_STALL + 1);
    localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(MAX_STALL);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             rsp_valid_q;
    logic             rsp_mem_q;
    logic             rsp_err_q;
    logic [31:0]      instr_hold_q;
    logic             load_err_q;
    logic             load_done_q;

    logic [IDX_W-1:0] fetch_idx, load_idx;
    logic             fetch_oob, fetch_mis, load_oob, load_mis;
    logic             fetch_ok, load_ok;
    logic             fetch_gnt, load_gnt;
    logic [31:0]      rsp_instr;

    imem_addr_decode #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_fetch_dec (
        .addr_i       (fetch_addr_i),
        .index_o      (fetch_idx),
        .oob_o        (fetch_oob),
        .misaligned_o (fetch_mis)
    );

    imem_addr_decode #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_load_dec (
        .addr_i       (load_addr_i),
        .index_o      (load_idx),
        .oob_o        (load_oob),
        .misaligned_o (load_mis)
    );

    assign fetch_ok = !fetch_oob && !fetch_mis;
    assign load_ok  = !load_oob && !load_mis;

    always_comb begin
        state_d   = state_q;
        stall_d   = stall_q;
        fetch_gnt = 1'b0;
        load_gnt  = 1'b0;
        unique case (state_q)
            RUN: begin
                // Loader has priority until fetch has lost MAX_STALL cycles in a row.
                fetch_gnt = fetch_valid_i && (!load_valid_i || (stall_q == STALL_MAX));
                load_gnt  = load_valid_i && !fetch_gnt;
                if (fetch_valid_i && !fetch_gnt) begin
                    stall_d = (stall_q == STALL_MAX) ? stall_q : stall_q + CNT_W'(1);
                end else begin
                    stall_d = '0;
                end
                if (prog_lock_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                stall_d = '0;
                state_d = LOCKED;
            end
            LOCKED: begin
                stall_d  = '0;
                load_gnt = load_valid_i;
                if (!prog_lock_i) begin
                    state_d = RUN;
                end
            end
            default: begin
                stall_d = '0;
                state_d = RUN;
            end
        endcase
        if (!rst_n) begin
            fetch_gnt = 1'b0;
            load_gnt  = 1'b0;
        end
    end

    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_index_o = '0;
        mem_wdata_o = '0;
        if (fetch_gnt && fetch_ok) begin
            mem_en_o    = 1'b1;
            mem_index_o = fetch_idx;
        end else if (load_gnt && load_ok) begin
            mem_en_o    = 1'b1;
            mem_we_o    = 1'b1;
            mem_index_o = load_idx;
            mem_wdata_o = load_data_i;
        end
    end

    // Read data arrives the cycle after the grant; the hold register keeps it stable afterwards.
    assign rsp_instr = rsp_valid_q ? (rsp_mem_q ? mem_rdata_i : NOP_INSTR) : instr_hold_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= RUN;
            stall_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_mem_q    <= 1'b0;
            rsp_err_q    <= 1'b0;
            instr_hold_q <= NOP_INSTR;
            load_err_q   <= 1'b0;
            load_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            stall_q      <= stall_d;
            rsp_valid_q  <= fetch_gnt;
            instr_hold_q <= rsp_instr;
            load_err_q   <= load_gnt && !load_ok;
            load_done_q  <= (state_q == LOCKED) && (state_d == RUN);
            if (fetch_gnt) begin
                rsp_mem_q <= fetch_ok;
                rsp_err_q <= fetch_mis;
            end
        end
    end

    assign fetch_ready_o     = fetch_gnt;
    assign load_ready_o      = load_gnt;
    assign fetch_rsp_valid_o = rsp_valid_q && rst_n;
    assign fetch_rsp_instr_o = rsp_instr;
    assign fetch_rsp_err_o   = rsp_err_q;
    assign load_err_o        = load_err_q && rst_n;
    assign load_done_o       = load_done_q && rst_n;
    assign lock_active_o     = (state_q == LOCKED);

endmodule

`default_nettype wire

// File: tb/tb_imem_port_arbiter.sv
// ==== tb_imem_port_arbiter : scoreboard bench for imem_port_arbiter with a behavioural memory (rev 1.0) ====
`default_nettype none

module tb_imem_port_arbiter;

    localparam logic [31:0] NOP = 32'h0000_0033;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_valid = 1'b0;
    logic        fetch_ready;
    logic [63:0] fetch_addr = '0;
    logic        fetch_rsp_valid;
    logic [31:0] fetch_rsp_instr;
    logic        fetch_rsp_err;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [63:0] load_addr = '0;
    logic [31:0] load_data = '0;
    logic        load_err;
    logic        prog_lock = 1'b0;
    logic        lock_active;
    logic        load_done;
    logic        mem_en;
    logic        mem_we;
    logic [8:0]  mem_index;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } rsp_t;

    rsp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          excl_viol = 0;
    logic [31:0] mem [0:511];

    imem_port_arbiter #(
        .ADDR_W    (64),
        .DEPTH     (512),
        .NOP_INSTR (32'h0000_0033),
        .MAX_STALL (4)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .fetch_valid_i     (fetch_valid),
        .fetch_ready_o     (fetch_ready),
        .fetch_addr_i      (fetch_addr),
        .fetch_rsp_valid_o (fetch_rsp_valid),
        .fetch_rsp_instr_o (fetch_rsp_instr),
        .fetch_rsp_err_o   (fetch_rsp_err),
        .load_valid_i      (load_valid),
        .load_ready_o      (load_ready),
        .load_addr_i       (load_addr),
        .load_data_i       (load_data),
        .load_err_o        (load_err),
        .prog_lock_i       (prog_lock),
        .lock_active_o     (lock_active),
        .load_done_o       (load_done),
        .mem_en_o          (mem_en),
        .mem_we_o          (mem_we),
        .mem_index_o       (mem_index),
        .mem_wdata_o       (mem_wdata),
        .mem_rdata_i       (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_index] <= mem_wdata;
            else        mem_rdata      <= mem[mem_index];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_one(input logic [63:0] a, input logic [31:0] ei, input logic ee,
                             input logic een, input logic [8:0] eidx);
        fetch_valid = 1'b1;
        fetch_addr  = a;
        #2;
        chk("fetch_ready", fetch_ready, 1);
        chk("fetch_mem_en", mem_en, een);
        if (een) chk("fetch_mem_index", mem_index, eidx);
        exp_q.push_back('{ei, ee});
        tick();
        fetch_valid = 1'b0;
    endtask

    // Monitor: every presented response must match the oldest expected one.
    always @(negedge clk) begin
        if (fetch_ready && load_ready) excl_viol++;
        if (fetch_rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 1, 0);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                chk("rsp_instr", fetch_rsp_instr, e.instr);
                chk("rsp_err", fetch_rsp_err, e.err);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 32'(i);
        mem[1]   = 32'h0010_8093;
        mem[22]  = 32'h1111_1111;
        mem[511] = 32'hCAFE_F00D;

        tick();
        tick();
        #2;
        chk("rst_fetch_ready", fetch_ready, 0);
        chk("rst_load_ready", load_ready, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_rsp_valid", fetch_rsp_valid, 0);
        chk("rst_rsp_instr", fetch_rsp_instr, NOP);
        chk("rst_lock_active", lock_active, 0);
        chk("rst_load_err", load_err, 0);
        chk("rst_load_done", load_done, 0);
        rst_n = 1'b1;
        tick();

        // Basic fetches, back-to-back, including bounds and alignment corners.
        fetch_one(64'h4,           32'h0010_8093, 1'b0, 1'b1, 9'd1);
        fetch_one(64'h2710,        NOP,           1'b0, 1'b0, 9'd0);
        fetch_one(64'h6,           NOP,           1'b1, 1'b0, 9'd0);
        fetch_one(64'h7FC,         32'hCAFE_F00D, 1'b0, 1'b1, 9'd511);
        fetch_one(64'h800,         NOP,           1'b0, 1'b0, 9'd0);
        fetch_one(64'h1_0000_0004, NOP,           1'b0, 1'b0, 9'd0);
        tick();

        // Starvation protection: 4 loader wins, then fetch, repeating.
        fetch_valid = 1'b1; fetch_addr = 64'h4;
        load_valid  = 1'b1; load_addr  = 64'h100; load_data = 32'h5;
        for (int i = 0; i < 10; i++) begin
            #2;
            chk("stall_fetch_ready", fetch_ready, (i % 5 == 4));
            chk("stall_load_ready", load_ready, (i % 5 != 4));
            if (i % 5 == 4) exp_q.push_back('{32'h0010_8093, 1'b0});
            tick();
        end
        fetch_valid = 1'b0; load_valid = 1'b0;
        tick();

        // Program lock with a fetch granted in the lock request cycle.
        fetch_valid = 1'b1; fetch_addr = 64'h58; prog_lock = 1'b1;
        #2;
        chk("lock_req_fetch_ready", fetch_ready, 1);
        exp_q.push_back('{32'h1111_1111, 1'b0});
        tick();
        #2;
        chk("drain_fetch_ready", fetch_ready, 0);
        chk("drain_lock_active", lock_active, 0);
        tick();
        load_valid = 1'b1; load_addr = 64'h58; load_data = 32'hA001_A001;
        #2;
        chk("locked_lock_active", lock_active, 1);
        chk("locked_fetch_ready", fetch_ready, 0);
        chk("locked_load_ready", load_ready, 1);
        chk("locked_mem_we", mem_we, 1);
        chk("locked_mem_index", mem_index, 22);
        chk("locked_mem_wdata", mem_wdata, 32'hA001_A001);
        tick();
        load_valid = 1'b0; prog_lock = 1'b0;
        #2;
        chk("unlock_lock_active", lock_active, 1);
        chk("unlock_fetch_ready", fetch_ready, 0);
        tick();
        #2;
        chk("run_load_done", load_done, 1);
        chk("run_lock_active", lock_active, 0);
        chk("run_fetch_ready", fetch_ready, 1);
        exp_q.push_back('{32'hA001_A001, 1'b0});
        tick();
        fetch_valid = 1'b0;
        #2;
        chk("run_load_done_pulse", load_done, 0);
        tick();

        // Lock dropped during DRAIN still visits LOCKED for one cycle.
        prog_lock = 1'b1;
        tick();
        prog_lock = 1'b0;
        #2;
        chk("drop_drain_lock", lock_active, 0);
        tick();
        #2;
        chk("drop_locked_lock", lock_active, 1);
        chk("drop_locked_done", load_done, 0);
        tick();
        #2;
        chk("drop_run_lock", lock_active, 0);
        chk("drop_run_done", load_done, 1);
        tick();

        // Dropped loader writes.
        load_valid = 1'b1; load_addr = 64'h2710; load_data = 32'hDEAD;
        #2;
        chk("lerr_oob_ready", load_ready, 1);
        chk("lerr_oob_mem_en", mem_en, 0);
        chk("lerr_oob_mem_we", mem_we, 0);
        tick();
        load_addr = 64'h6D;
        #2;
        chk("lerr_oob_pulse", load_err, 1);
        chk("lerr_mis_mem_we", mem_we, 0);
        tick();
        load_addr = 64'h8; load_data = 32'h77;
        #2;
        chk("lerr_mis_pulse", load_err, 1);
        chk("lok_mem_we", mem_we, 1);
        tick();
        load_valid = 1'b0;
        #2;
        chk("lok_no_err", load_err, 0);
        tick();
        fetch_one(64'h8, 32'h77, 1'b0, 1'b1, 9'd2);
        tick();

        // Reset clears a partially built stall count.
        fetch_valid = 1'b1; fetch_addr = 64'h4;
        load_valid  = 1'b1; load_addr  = 64'h100;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("pre_rst_load_ready", load_ready, 1);
            tick();
        end
        rst_n = 1'b0;
        #2;
        chk("in_rst_fetch_ready", fetch_ready, 0);
        chk("in_rst_load_ready", load_ready, 0);
        chk("in_rst_mem_en", mem_en, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #2;
            chk("post_rst_fetch_ready", fetch_ready, (i == 4));
            if (i == 4) exp_q.push_back('{32'h0010_8093, 1'b0});
            tick();
        end
        fetch_valid = 1'b0; load_valid = 1'b0;
        tick();

        // Reset right after a fetch grant drops the in-flight response.
        fetch_valid = 1'b1; fetch_addr = 64'h4;
        #2;
        chk("inflight_fetch_ready", fetch_ready, 1);
        tick();
        fetch_valid = 1'b0; rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #2;
        chk("inflight_rsp_valid", fetch_rsp_valid, 0);
        chk("inflight_rsp_instr", fetch_rsp_instr, NOP);
        chk("inflight_rsp_err", fetch_rsp_err, 0);
        chk("inflight_lock_active", lock_active, 0);
        tick();
        tick();

        chk("queue_empty", exp_q.size(), 0);
        chk("ready_exclusive", excl_viol, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
